// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared encodings for the two-master AXI-lite read arbiter.
// Round-robin arbitration is enabled with `define YSYX_22050019_ARB_RR_EN.
package ysyx_22050019_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_RESP  = 3'd2,
        S_ERR   = 3'd3,
        S_DRAIN = 3'd4
    } arb_state_e;

    // Plain vector constants so the state register stays a simple logic vector.
    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_ADDR  = S_ADDR;
    localparam logic [2:0] ST_RESP  = S_RESP;
    localparam logic [2:0] ST_ERR   = S_ERR;
    localparam logic [2:0] ST_DRAIN = S_DRAIN;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_M0   = 2'b01;
    localparam logic [1:0] G_M1   = 2'b10;

    // Priority pointer value after serving 'served': favour the other master.
    function automatic logic prio_after(input logic [1:0] served);
        return served[0];
    endfunction

endpackage

// File: rtl/ysyx_22050019_arb_sel.sv
// Two-requester picker: one-hot grant from req[1:0]; prio=1 favours m1 on a tie.
// The caller decides whether prio is a live pointer or a constant.
module ysyx_22050019_arb_sel
    import ysyx_22050019_axi_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = G_NONE;
        if (req == 2'b11) begin
            gnt = prio ? G_M1 : G_M0;
        end else if (req[1]) begin
            gnt = G_M1;
        end else if (req[0]) begin
            gnt = G_M0;
        end
    end

endmodule

// File: rtl/ysyx_22050019_axi_rd_arb.sv
// Two-master to one-slave AXI-lite read arbiter with a response watchdog.
// `define YSYX_22050019_ARB_RR_EN selects round-robin instead of fixed m1>m0.
module ysyx_22050019_axi_rd_arb
    import ysyx_22050019_axi_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,

    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,

    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:0] s_araddr,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,

    output logic [1:0]        grant_o
);

    localparam bit             WD_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WD_MAX   = {CNT_W{1'b1}};

    logic [2:0]        state, state_nxt;
    logic [1:0]        grant, grant_nxt;
    logic [CNT_W-1:0]  wd_cnt, wd_nxt;
    logic [1:0]        sel_gnt;
    logic              prio;

    logic              g0, g1;
    logic              gr_arvalid, gr_rready;
    logic [ADDR_W-1:0] gr_araddr;
    logic              ar_hs, r_hs, err_done;

    assign g0 = (grant == G_M0);
    assign g1 = (grant == G_M1);

    assign gr_arvalid = (g0 & m0_arvalid) | (g1 & m1_arvalid);
    assign gr_rready  = (g0 & m0_rready)  | (g1 & m1_rready);
    assign gr_araddr  = g1 ? m1_araddr : (g0 ? m0_araddr : '0);

    assign ar_hs    = (state == ST_ADDR) && gr_arvalid && s_arready;
    assign r_hs     = (state == ST_RESP) && s_rvalid && gr_rready;
    assign err_done = (state == ST_ERR) && gr_rready;

    ysyx_22050019_arb_sel u_sel (
        .req  ({m1_arvalid, m0_arvalid}),
        .prio (prio),
        .gnt  (sel_gnt)
    );

`ifdef YSYX_22050019_ARB_RR_EN
    logic prio_q;

    // Pointer moves on every completed transaction, normal or error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (r_hs || err_done) begin
            prio_q <= prio_after(grant);
        end
    end

    assign prio = prio_q;
`else
    assign prio = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        wd_nxt    = wd_cnt;
        case (state)
            ST_IDLE: begin
                if (sel_gnt != G_NONE) begin
                    grant_nxt = sel_gnt;
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ar_hs) begin
                    state_nxt = ST_RESP;
                    wd_nxt    = '0;
                end
            end
            ST_RESP: begin
                if (r_hs) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = G_NONE;
                end else begin
                    // Saturating count of RESP cycles that saw no handshake.
                    if (wd_cnt != WD_MAX) begin
                        wd_nxt = wd_cnt + CNT_W'(1);
                    end
                    if (WD_EN && (wd_nxt == WD_LIMIT)) begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                if (err_done) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (s_rvalid) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = G_NONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = G_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            grant  <= G_NONE;
            wd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            wd_cnt <= wd_nxt;
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid is never gated by ready, and the non-granted master sees all zeros.
    always_comb begin
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        m0_rresp   = RESP_OKAY;
        m1_rresp   = RESP_OKAY;
        case (state)
            ST_ADDR: begin
                s_arvalid  = gr_arvalid;
                s_araddr   = gr_araddr;
                m0_arready = g0 & s_arready;
                m1_arready = g1 & s_arready;
            end
            ST_RESP: begin
                s_rready  = gr_rready;
                m0_rvalid = g0 & s_rvalid;
                m1_rvalid = g1 & s_rvalid;
                if (g0) begin
                    m0_rdata = s_rdata;
                    m0_rresp = s_rresp;
                end
                if (g1) begin
                    m1_rdata = s_rdata;
                    m1_rresp = s_rresp;
                end
            end
            ST_ERR: begin
                m0_rvalid = g0;
                m1_rvalid = g1;
                if (g0) m0_rresp = RESP_SLVERR;
                if (g1) m1_rresp = RESP_SLVERR;
            end
            ST_DRAIN: begin
                // The late slave beat is swallowed here; masters see nothing.
                s_rready = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign grant_o = grant;

endmodule

// File: tb/tb_ysyx_22050019_axi_rd_arb.sv
// Randomised scoreboard bench for ysyx_22050019_axi_rd_arb (TIMEOUT=8).
// Builds in both arbitration modes; the reference model follows YSYX_22050019_ARB_RR_EN.
module tb_ysyx_22050019_axi_rd_arb;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
    logic [63:0] m_araddr [2];
    logic [63:0] m_rdata [2];
    logic [1:0]  m_rresp [2];
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [63:0] s_araddr, s_rdata;
    logic [1:0]  s_rresp;
    logic [1:0]  grant_o;

    int errors = 0;
    int checks = 0;

    logic [65:0] exp_q0[$];
    logic [65:0] exp_q1[$];
    int          served_q[$];
    int          fav;

    bit          slave_drop = 1'b0, bad_data = 1'b0, rand_ar = 1'b0, rand_r = 1'b0;
    bit          rr_hold = 1'b0, rr_rand = 1'b0;
    int          ar_stall = 0;
    bit          sl_pend;
    logic [63:0] sl_addr;
    int          sl_delay;

    ysyx_22050019_axi_rd_arb #(
        .ADDR_W(64), .DATA_W(64), .TIMEOUT(TMO), .CNT_W(9)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]), .m0_araddr(m_araddr[0]),
        .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]), .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]),
        .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]), .m1_araddr(m_araddr[1]),
        .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]), .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .grant_o(grant_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        errors++;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "bench time limit");
    end

    // ---------------- reference helpers ----------------
    function automatic logic [63:0] mem_data(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0013;
        return {a[31:0] ^ 32'h5A5A_A5A5, ~a[31:0]};
    endfunction

    // Winner for the set of requesters seen in the IDLE cycle.
    function automatic logic [1:0] pick(input logic [1:0] req, input int favour);
        if (req == 2'b11) return (favour == 1) ? 2'b10 : 2'b01;
        return req;
    endfunction

    function automatic int fav_reset();
`ifdef YSYX_22050019_ARB_RR_EN
        return 0;
`else
        return 1;
`endif
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic m_read(input int m, input logic [63:0] addr);
        logic [65:0] e;
        e = slave_drop ? {2'b10, 64'h0} : {2'b00, mem_data(addr)};
        if (m == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        m_araddr[m]  = addr;
        m_arvalid[m] = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (m_arready[m]) break;
            if (t == 299) check("ar_wait_bound", 1'b1, 1'b0);
        end
        @(posedge clk); #1;
        m_arvalid[m] = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (exp_q0.size() == 0 && exp_q1.size() == 0 && grant_o == 2'b00) done = 1'b1;
        end
        check("drain_bound", done, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic random_master(input int m, input int n);
        for (int i = 0; i < n; i++) begin
            m_read(m, 64'h8000_0000 + 64'({$urandom_range(0, 4095), 3'b000}));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    // ---------------- slave model ----------------
    initial begin : slave
        bit          ar_fire, r_fire;
        logic [63:0] a;
        s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
        sl_pend = 1'b0; sl_addr = '0; sl_delay = 0;
        forever begin
            @(negedge clk);
            ar_fire = s_arvalid && s_arready;
            r_fire  = s_rvalid && s_rready;
            a       = s_araddr;
            @(posedge clk); #2;
            if (!rst_n) begin
                s_rvalid = 1'b0; sl_pend = 1'b0; s_arready = 1'b1;
            end else begin
                if (r_fire) begin s_rvalid = 1'b0; sl_pend = 1'b0; end
                if (ar_fire) begin
                    sl_pend  = 1'b1;
                    sl_addr  = a;
                    sl_delay = rand_r ? int'($urandom_range(0, 3)) : 0;
                end
                if (sl_pend && !s_rvalid && !slave_drop) begin
                    if (sl_delay == 0) begin
                        s_rvalid = 1'b1;
                        s_rdata  = bad_data ? 64'hDEAD : mem_data(sl_addr);
                        s_rresp  = 2'b00;
                    end else begin
                        sl_delay--;
                    end
                end
                if (ar_stall > 0) begin
                    s_arready = 1'b0;
                    ar_stall--;
                end else begin
                    s_arready = rand_ar ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
            end
        end
    end

    // ---------------- master rready driver ----------------
    initial begin : rready_drv
        int lows [2];
        lows[0] = 0; lows[1] = 0;
        m_rready = 2'b11;
        forever begin
            @(posedge clk); #3;
            for (int m = 0; m < 2; m++) begin
                if (m == 0 && rr_hold) begin
                    m_rready[0] = 1'b0;
                end else if (!rr_rand || lows[m] >= 2 || $urandom_range(0, 2) != 0) begin
                    m_rready[m] = 1'b1;
                    lows[m] = 0;
                end else begin
                    m_rready[m] = 1'b0;
                    lows[m]++;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [65:0] e;
        logic [1:0]  prev_grant, prev_req;
        int          o;
        prev_grant = 2'b00; prev_req = 2'b00; fav = fav_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_grant = 2'b00; prev_req = 2'b00; fav = fav_reset();
            end else begin
                if (prev_grant == 2'b00 && grant_o != 2'b00)
                    check("grant_pick", grant_o, pick(prev_req, fav));
                for (int m = 0; m < 2; m++) begin
                    if (m_arvalid[m] && m_arready[m]) begin
                        served_q.push_back(m);
                        check("ar_addr", s_araddr, m_araddr[m]);
                    end
                    if (m_rvalid[m] && m_rready[m]) begin
                        if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
                            check("unexpected_r", m_rdata[m], 64'h0);
                            check("unexpected_r_valid", m_rvalid[m], 1'b0);
                        end else begin
                            e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            check((m == 0) ? "r_beat_m0" : "r_beat_m1", {m_rresp[m], m_rdata[m]}, e);
                        end
`ifdef YSYX_22050019_ARB_RR_EN
                        fav = (m == 0) ? 1 : 0;
`endif
                    end
                end
                if (grant_o == 2'b01 || grant_o == 2'b10) begin
                    o = grant_o[0] ? 1 : 0;
                    check("ungranted_quiet", {m_arready[o], m_rvalid[o], m_rresp[o], m_rdata[o]}, '0);
                end
                prev_grant = grant_o;
                prev_req   = m_arvalid;
            end
        end
    end

    // ---------------- directed + random sequence ----------------
    initial begin : main
        int lat, exp_first;
        m_arvalid = 2'b00; m_araddr[0] = '0; m_araddr[1] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valids", {s_arvalid, s_rready, m_arready, m_rvalid}, '0);
        check("rst_grant", grant_o, 2'b00);
        check("rst_data", {s_araddr | m_rdata[0] | m_rdata[1], m_rresp[0], m_rresp[1]}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single m0 read with a zero-wait slave
        fork
            m_read(0, 64'h8000_0000);
            begin
                lat = 0;
                for (int t = 0; t < 50; t++) begin
                    @(negedge clk);
                    lat++;
                    if (m_rvalid[0]) break;
                end
                check("m0_latency", lat, 3);
                check("m0_first_data", m_rdata[0], 64'h13);
            end
        join
        @(posedge clk); #1;
        @(negedge clk);
        check("grant_back_idle", grant_o, 2'b00);
        wait_drain();

        // two simultaneous pairs; winner follows the model pointer
        for (int p = 0; p < 2; p++) begin
            served_q.delete();
            exp_first = fav;
            fork
                m_read(0, 64'h8000_0000);
                m_read(1, 64'h8000_1000);
            join
            wait_drain();
            check("pair_count", served_q.size(), 2);
            if (served_q.size() == 2) begin
                check("pair_first", served_q[0], exp_first);
                check("pair_second", served_q[1], 1 - exp_first);
            end
        end

        // slave stalls arready for 5 ADDR cycles
        fork
            begin
                ar_stall = 6;
                m_read(1, 64'h8000_1008);
            end
            begin
                @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_m1_arready", m_arready[1], 1'b0);
                    check("stall_m0_arready", m_arready[0], 1'b0);
                    check("stall_addr", {s_arvalid, s_araddr}, {1'b1, 64'h8000_1008});
                end
                @(negedge clk);
                check("stall_release", {m_arready[1], grant_o}, {1'b1, 2'b10});
            end
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                m_read(0, 64'h8000_0010);
            end
        join
        wait_drain();

        // lost response: watchdog error, then a discarded late beat
        slave_drop = 1'b1;
        bad_data   = 1'b1;
        m_read(0, 64'h8000_2000);
        lat = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            lat++;
            if (m_rvalid[0]) break;
        end
        check("err_latency", lat, TMO + 1);
        check("err_beat", {m_rresp[0], m_rdata[0], s_rready, s_arvalid}, {2'b10, 64'h0, 2'b00});
        @(posedge clk); #1;
        repeat (2) @(negedge clk);
        check("drain_state", {s_rready, m_rvalid, grant_o}, {1'b1, 2'b00, 2'b01});
        @(posedge clk); #1;
        slave_drop = 1'b0;
        @(negedge clk);
        check("drain_hidden", {s_rvalid, s_rready, m_rvalid}, {2'b11, 2'b00});
        @(negedge clk);
        check("drain_exit", grant_o, 2'b00);
        bad_data = 1'b0;
        wait_drain();

        // reset in the middle of RESP
        slave_drop = 1'b1;
        m_read(0, 64'h8000_3000);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valids", {s_arvalid, s_rready, m_arready, m_rvalid}, '0);
        check("midrst_grant", grant_o, 2'b00);
        exp_q0.delete();
        slave_drop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_read(0, 64'h8000_3008);
        wait_drain();

        // master back-pressure for 4 RESP cycles
        rr_hold = 1'b1;
        m_read(0, 64'h8000_4000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_s_rready", s_rready, 1'b0);
            check("hold_pass", {m_rvalid[0], m_rresp[0], m_rdata[0]}, {1'b1, 2'b00, mem_data(64'h8000_4000)});
        end
        @(posedge clk); #1;
        rr_hold = 1'b0;
        wait_drain();

        // randomised concurrent traffic
        rand_ar = 1'b1; rand_r = 1'b1; rr_rand = 1'b1;
        fork
            random_master(0, 30);
            random_master(1, 30);
        join
        wait_drain();
        check("final_queues", exp_q0.size() + exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_axi_rd_arb.md
Name: ysyx_22050019_axi_rd_arb

Overview:
- Two-master to one-slave AXI-lite read-channel arbiter; shares the single instruction/data memory read port between the fetch stage (m0) and the load/store unit (m1).
- Single-beat reads, one outstanding transaction, registered grant.
- Includes a response watchdog so a lost read response cannot hang the pipeline.
- Sits between the pipeline front/back ends and the memory/crossbar.

Parameters:
- ADDR_W, 64, address width of all AR channels
- DATA_W, 64, read data width of all R channels
- TIMEOUT, 256, cycles to wait in RESP before error-completing; 0 disables the watchdog
- CNT_W, 9, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- m0_arvalid  in  1  fetch read request
- m0_arready  out  1  fetch request accepted
- m0_araddr  in  ADDR_W  fetch address
- m0_rvalid  out  1  fetch data valid
- m0_rready  in  1  fetch ready for data
- m0_rdata  out  DATA_W  fetch data
- m0_rresp  out  2  fetch response (00 OKAY, 10 SLVERR)
- m1_arvalid, m1_arready, m1_araddr, m1_rvalid, m1_rready, m1_rdata, m1_rresp: same as m0_*, for the LSU
- s_arvalid  out  1  to memory
- s_arready  in  1
- s_araddr  out  ADDR_W
- s_rvalid  in  1
- s_rready  out  1
- s_rdata  in  DATA_W
- s_rresp  in  2
- grant_o  out  2  one-hot current owner, for debug/perf counters; 00 when idle

Behaviour:
- States: IDLE, ADDR, RESP, ERR, DRAIN; state and grant are registered.
- Reset (async, rst_n=0): state=IDLE, grant=00, watchdog=0, priority pointer=m0. While in reset, all valid/ready outputs are 0, all data outputs are 0, and rresp outputs are 00.
- IDLE:
  - If any mX_arvalid, latch the grant and go to ADDR.
  - Fixed priority: m1 (LSU) over m0.
  - No output handshakes occur in IDLE. The arbitration bubble is 1 cycle: a request at cycle N reaches s_arvalid at N+1.
- ADDR:
  - s_arvalid = granted mX_arvalid; s_araddr = granted address.
  - Granted mX_arready = s_arready; the non-granted master sees arready=0.
  - On s_arvalid && s_arready: go to RESP and clear the watchdog.
  - If the granted master drops arvalid (a protocol violation), stay in ADDR; there is no regrant.
- RESP:
  - Granted mX_rvalid = s_rvalid; mX_rdata = s_rdata; mX_rresp = s_rresp; s_rready = granted mX_rready.
  - On the s_rvalid && s_rready handshake: go to IDLE and clear the grant.
  - The watchdog increments on every RESP cycle without a handshake. When it reaches TIMEOUT (TIMEOUT!=0), go to ERR.
- ERR:
  - Granted mX_rvalid=1, rdata=0, rresp=10.
  - s_rready=0 and s_arvalid=0.
  - On master rready, go to DRAIN.
- DRAIN:
  - s_rready=1; the late slave beat is consumed and discarded with no master visibility.
  - On s_rvalid, go to IDLE.
- Non-granted master: rvalid=0, rdata=0, rresp=00 in every state.
- A back-to-back request from the same master may re-win in the IDLE cycle following completion. Minimum per-transaction latency is 3 cycles with a zero-wait slave (IDLE, ADDR, RESP).
- Watchdog saturates; it never wraps.
- Combinational paths exist from slave ready/valid to master ready/valid. There is no combinational path from any input to grant.

Optional Feature:
- Macro YSYX_22050019_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit priority pointer is updated on every completed transaction (RESP handshake or ERR exit) to favour the master not just served. On simultaneous requests the favoured master wins.
- Undefined: fixed priority m1 > m0; no pointer register exists.

Decomposition:
- Package ysyx_22050019_axi_pkg:
  - state enum (IDLE/ADDR/RESP/ERR/DRAIN)
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - grant encodings G_NONE/G_M0/G_M1
- One sub-module ysyx_22050019_arb_sel: combinational two-requester picker (req[1:0], prio pointer → one-hot grant). It isolates the RR_EN variant.

Test Plan:
- Single m0 read, addr 0x8000_0000, slave arready/rvalid immediate, rdata 0x0000_0013 → m0_rvalid at cycle 3, m0_rdata=0x13, rresp=00, grant_o returns to 00.
- m0 and m1 request the same cycle, addrs 0x8000_0000 / 0x8000_1000:
  - fixed mode → m1 served first, m0 second.
  - RR_EN with pointer=m0 → m0 first; the next simultaneous pair → m1 first.
- Slave holds arready=0 for 5 cycles → m1_arready stays 0, s_araddr stable at the granted addr, m0 never sees arready; the handshake completes on cycle 6.
- TIMEOUT=8, slave never asserts rvalid → on the 8th RESP cycle, granted master gets rvalid=1, rresp=10, rdata=0. In DRAIN, a later s_rvalid with 0xDEAD is discarded and the block returns to IDLE.
- rst_n asserted mid-RESP → same cycle: all valids/readys 0, grant_o=00. After release, a new m0 request proceeds normally.
- Master holds rready=0 for 4 cycles during RESP → s_rready=0 for those cycles, data passes through unchanged, and no watchdog expiry occurs with TIMEOUT=256.
